f1_launch_ctrl: RTL
===================

Name: f1_launch_ctrl

Overview:
Timing controller directly upstream of the F1 start-light FSM. It drives that FSM's enable input.
- On a start trigger it issues eight evenly spaced single-cycle enable pulses, lighting lights 1..8.
- It then waits a pseudo-random hold period and issues a ninth pulse, which returns the lights FSM to all-off.
- It flags that ninth pulse as "lights out".
- It contains the tick divider and a 7-bit LFSR delay source.

Parameters:
WIDTH, 16, width of tick period input and tick down-counter
N_LIGHTS, 8, number of lighting pulses before the hold phase
LFSR_WIDTH, 7, width of LFSR and of the hold multiplier

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
trigger  input  1  start request, level-sampled each cycle in IDLE
n  input  WIDTH  tick period minus one (a tick occurs every n+1 cycles)
en_out  output  1  single-cycle advance pulse to the lights FSM en input
lights_out  output  1  single-cycle pulse coincident with the final (ninth) en_out
busy  output  1  high whenever state is not IDLE
step  output  4  count of en_out pulses issued in the current sequence (0..N_LIGHTS)

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst_n low, asynchronously):
  - state=IDLE; en_out, lights_out, busy = 0; step=0.
  - Tick counter=0, hold counter=0, LFSR=7'h01.
- Reset mid-sequence aborts immediately. No further pulses are issued until a new trigger.
- LFSR:
  - Free-running every cycle regardless of state.
  - next = {lfsr[5:0], lfsr[6]^lfsr[2]} (x^7+x^3+1, maximal length).
  - Never zero. Sequence from seed: 01,02,04,09,...
- Tick: tick_cnt==0 in LIGHTING or HOLD. On a tick, tick_cnt reloads from the current n; otherwise it decrements. n is sampled only at load/reload.
- States: IDLE, LIGHTING, HOLD.
- IDLE:
  - trigger=1 -> LIGHTING next cycle; tick_cnt<=n; step<=0.
  - trigger=0 -> stay.
- LIGHTING:
  - On each tick: en_out=1 that cycle; step increments.
  - When the tick issues the N_LIGHTS-th pulse: hold_cnt<=LFSR value present that cycle (range 1..127); tick_cnt<=n; -> HOLD.
- HOLD:
  - On each tick: if hold_cnt==1, en_out=1 and lights_out=1 that cycle, step<=0, -> IDLE.
  - Otherwise hold_cnt decrements.
- Timing: with trigger high in cycle t:
  - en_out is high in cycles t+1+n+k(n+1), k=0..7.
  - Final pulse falls D(n+1) cycles after the 8th pulse, where D is the captured LFSR value.
  - n=0 gives consecutive-cycle pulses.
- trigger is ignored while busy. A trigger held high through the return to IDLE restarts on the following cycle (no edge detection).
- en_out and lights_out are combinational from registered state/counters; there are no glitches on the clock edge domain.
- All counters wrap-free: tick_cnt and hold_cnt never underflow, because they are reloaded on zero/one.

Decomposition:
- Package f1_pkg holds:
  - state enum (IDLE, LIGHTING, HOLD)
  - LFSR_SEED=7'h01
  - LFSR tap positions
  - N_LIGHTS default
- Sub-module f1_lfsr7 (clk, rst_n, q[6:0]): free-running LFSR, instantiated once.
- The remainder is a single FSM with two down-counters.

Test Plan:
- Reset: rst_n low mid-LIGHTING at step=3 -> outputs and step read 0 immediately (before the next clk edge); no en_out until the next trigger.
- n=3, trigger pulsed at cycle 0 -> en_out high exactly at cycles 4,8,...,32; step reads 1..8; busy high from cycle 1.
- n=0, trigger at cycle 0 -> en_out high cycles 1..8 back-to-back. Then the bench's LFSR reference model gives D, and the final en_out+lights_out occur exactly D cycles after cycle 8.
- LFSR check: after reset release, f1_lfsr7 q reads 01,02,04,09 on the first four cycles; a full 127-cycle period is observed with no zero value.
- Trigger held high through the whole sequence -> no extra pulses while busy; a new sequence starts the cycle after return to IDLE.
- Change n from 3 to 1 during LIGHTING -> the new spacing (2 cycles) takes effect from the next reload only; the current interval completes with 4.

Source files
------------

// File: rtl/f1_pkg.sv
// Shared types and constants for the F1 launch timing controller.
package f1_pkg;
  typedef enum logic [1:0] {IDLE, LIGHTING, HOLD} state_e;

  localparam logic [6:0] LFSR_SEED   = 7'h01;
  localparam int         LFSR_TAP_HI = 6;
  localparam int         LFSR_TAP_LO = 2;
  localparam int         N_LIGHTS_DEF = 8;
endpackage

// File: rtl/f1_lfsr7.sv
// Free-running 7-bit Fibonacci LFSR (x^7+x^3+1); never reaches zero from the seed.
module f1_lfsr7
  import f1_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [6:0] q
);
  logic [6:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= LFSR_SEED;
    else        q_q <= {q_q[5:0], q_q[LFSR_TAP_HI] ^ q_q[LFSR_TAP_LO]};
  end

  assign q = q_q;
endmodule

// File: rtl/f1_launch_ctrl.sv
// Drives the start-light FSM: N_LIGHTS evenly spaced enables, a random hold,
// then a final enable flagged as lights-out.
module f1_launch_ctrl
  import f1_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int N_LIGHTS   = N_LIGHTS_DEF,
  parameter int LFSR_WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trigger,
  input  logic [WIDTH-1:0] n,
  output logic             en_out,
  output logic             lights_out,
  output logic             busy,
  output logic [3:0]       step
);
  localparam logic [3:0] LAST_STEP = 4'(N_LIGHTS - 1);

  state_e                state_q, state_d;
  logic [WIDTH-1:0]      tick_q, tick_d;
  logic [LFSR_WIDTH-1:0] hold_q, hold_d;
  logic [3:0]            step_q, step_d;
  logic [6:0]            lfsr;
  logic                  tick;

  f1_lfsr7 u_lfsr (.clk(clk), .rst_n(rst_n), .q(lfsr));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tick_q  <= '0;
      hold_q  <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      hold_q  <= hold_d;
      step_q  <= step_d;
    end
  end

  assign tick = (tick_q == '0);

  always_comb begin
    state_d    = state_q;
    tick_d     = tick_q;
    hold_d     = hold_q;
    step_d     = step_q;
    en_out     = 1'b0;
    lights_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d = LIGHTING;
          tick_d  = n;
          step_d  = '0;
        end
      end
      LIGHTING: begin
        if (tick) begin
          en_out = 1'b1;
          step_d = step_q + 4'd1;
          tick_d = n;
          if (step_q == LAST_STEP) begin
            // Capture the LFSR value live in this cycle as the hold multiplier.
            hold_d  = LFSR_WIDTH'(lfsr);
            state_d = HOLD;
          end
        end else begin
          tick_d = tick_q - WIDTH'(1);
        end
      end
      HOLD: begin
        if (tick) begin
          tick_d = n;
          if (hold_q == LFSR_WIDTH'(1)) begin
            en_out     = 1'b1;
            lights_out = 1'b1;
            step_d     = '0;
            state_d    = IDLE;
          end else begin
            hold_d = hold_q - LFSR_WIDTH'(1);
          end
        end else begin
          tick_d = tick_q - WIDTH'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q != IDLE);
  assign step = step_q;
endmodule
